sprite_eval_ctrl: RTL and testbench
===================================

Name: sprite_eval_ctrl

Overview:
- Per-scanline sprite evaluation sequencer for the sprite engine.
- On each line-start pulse it walks sprite indices 0..NUM_SPRITES-1 through the sprite attribute RAM, one read per cycle, pipelined.
- Each sprite is tested for vertical coverage of the current line. Up to MAX_PER_LINE hits are emitted, in ascending index order, to the line sprite buffer.
- Flags overflow and aborts the scan early when more sprites than MAX_PER_LINE cover the line.

Parameters:
- NUM_SPRITES, 256: sprites scanned per line; power of two, at most 256.
- MAX_PER_LINE, 8: hit slots per line; power of two, at most 16.
- SPRITE_H, 16: sprite height in lines.
- Y_W, 8: width of Y coordinates.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins evaluation; honoured only when busy=0.
- line_y  in  Y_W  current scanline; sampled on an accepted start.
- attr_rd_en  out  1  attribute RAM read strobe.
- attr_addr  out  8  sprite index being read.
- attr_y  in  Y_W  sprite top Y; valid the cycle after attr_rd_en.
- attr_en  in  1  sprite-enabled flag; same timing as attr_y.
- hit_valid  out  1  one-cycle pulse: a sprite was selected.
- hit_idx  out  8  index of the selected sprite; valid with hit_valid.
- hit_slot  out  log2(MAX_PER_LINE)  slot number 0..MAX_PER_LINE-1; valid with hit_valid.
- hit_count  out  log2(MAX_PER_LINE)+1  number of hits this line; held until the next accepted start.
- overflow  out  1  set when more than MAX_PER_LINE sprites cover the line; held until the next accepted start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse marking the end of evaluation.

Behaviour:
- Reset: every output 0; FSM in IDLE; internal index counter 0; latched line_y 0.
- FSM states: IDLE, SCAN, DRAIN, FIN.
- IDLE: on start, latch line_y, clear hit_count and overflow, go to SCAN.
- SCAN: each cycle assert attr_rd_en with attr_addr = idx, then increment idx. Each cycle, also evaluate the response to the previous cycle's read.
  - After issuing idx = NUM_SPRITES-1, go to DRAIN.
- DRAIN: evaluate the final read; no read is issued; go to FIN.
- FIN: pulse done; go to IDLE.
- Hit test, computed in Y_W+1 bits with no wrap: attr_en=1 AND attr_y <= line_y AND line_y < attr_y + SPRITE_H.
  - A sprite with attr_y=250 covers lines 250..255 only.
- Hit while hit_count < MAX_PER_LINE: pulse hit_valid, with hit_idx = the evaluated index and hit_slot = hit_count; then hit_count increments.
- Hit while hit_count == MAX_PER_LINE:
  - Set overflow, with no hit_valid.
  - Deassert attr_rd_en immediately and discard the in-flight read.
  - Go to FIN. done follows on the next cycle.
- Nominal latency: start accepted at cycle 0 gives reads in cycles 1..NUM_SPRITES, the last evaluation in cycle NUM_SPRITES+1, and done in cycle NUM_SPRITES+2 (258 by default).
- busy=1 in SCAN, DRAIN and FIN.
- start while busy=1, including the done cycle: ignored, with no side effects.
- Index counter wraps to 0 on entry to SCAN. The evaluated index is a one-cycle-delayed copy of attr_addr.
- Reset asserted mid-scan: immediate return to reset values; no done pulse.
- hit_valid and done are never asserted in the same cycle.

Decomposition:
- Shared package sprite_pkg holds:
  - eval_state_t enum (IDLE, SCAN, DRAIN, FIN);
  - constants NUM_SPRITES, MAX_PER_LINE, SPRITE_H;
  - derived widths IDX_W and SLOT_W.
- One sub-module, sprite_idx_ctr: 8-bit index counter with synchronous clear, increment enable, and a terminal flag at NUM_SPRITES-1.
- The hit comparator stays inline.

Test Plan:
- No sprites enabled (attr_en=0 for all), line_y=100, start -> 256 reads at addr 0..255, no hit_valid, done at cycle 258, hit_count=0, overflow=0.
- Sprites 3, 40 and 255 enabled with attr_y=95, line_y=100 -> hit_valid 3 times with hit_idx 3/40/255 and hit_slot 0/1/2; hit_count=3; the hit for idx 255 arrives in cycle 257.
- Boundary: attr_y=85 (covers lines 85..100) and attr_y=84 (covers 84..99), line_y=100 -> only the 85 sprite hits. attr_y=250, line_y=5 -> no hit (no wrap).
- Overflow: sprites 0..9 all cover the line -> hits for idx 0..7 in slots 0..7; at the evaluation of idx 8, overflow=1 and reads stop; done 1 cycle later; hit_count=8; no read at addr > 9.
- start pulsed mid-SCAN and again on the done cycle -> both ignored; hit_count and overflow unchanged; a fresh start afterwards clears them.
- rst_n low at cycle 50 of a scan -> all outputs 0 asynchronously, no done; a new start after reset begins at addr 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the per-scanline sprite evaluation sequencer:
// geometry constants, derived widths and the evaluation FSM state type.
package sprite_pkg;

   localparam int NUM_SPRITES  = 256;
   localparam int MAX_PER_LINE = 8;
   localparam int SPRITE_H     = 16;
   localparam int Y_W          = 8;

   // Attribute RAM addresses and sprite indices are always carried on 8 bits.
   localparam int ADDR_W = 8;
   localparam int IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int SLOT_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
   localparam int CNT_W  = SLOT_W + 1;

   // Index of the last sprite visited on a line.
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SPRITES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } eval_state_t;

endpackage

// File: rtl/sprite_eval_ctrl_idx_ctr.sv
// Sprite index counter: walks attribute RAM addresses, cleared when a new
// line evaluation starts, with a flag marking the last sprite index.
module sprite_idx_ctr
   import sprite_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_idx,
   output logic              o_last
);

   logic [ADDR_W-1:0] r_idx;

   // Clear has priority so a new line always begins at sprite 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
      end else if (i_inc) begin
         r_idx <= r_idx + 1'b1;
      end
   end

   assign o_idx  = r_idx;
   assign o_last = (r_idx == LAST_IDX);

endmodule

// File: rtl/sprite_eval_ctrl.sv
// Per-scanline sprite evaluation sequencer. Reads every sprite's attributes
// once per line (one read per cycle, response one cycle later), tests each
// sprite for vertical coverage of the line and hands up to MAX_PER_LINE hits
// to the line sprite buffer in ascending index order. A further covering
// sprite flags overflow and ends the scan early.
module sprite_eval_ctrl
   import sprite_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [Y_W-1:0]    i_line_y,
   output logic              o_attr_rd_en,
   output logic [ADDR_W-1:0] o_attr_addr,
   input  logic [Y_W-1:0]    i_attr_y,
   input  logic              i_attr_en,
   output logic              o_hit_valid,
   output logic [ADDR_W-1:0] o_hit_idx,
   output logic [SLOT_W-1:0] o_hit_slot,
   output logic [CNT_W-1:0]  o_hit_count,
   output logic              o_overflow,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PER_LINE);
   localparam logic [Y_W:0]     HEIGHT  = (Y_W + 1)'(SPRITE_H);

   eval_state_t       r_state;
   eval_state_t       w_nextState;
   logic [Y_W-1:0]    r_lineY;
   logic              r_evalValid;
   logic [ADDR_W-1:0] r_evalIdx;
   logic [CNT_W-1:0]  r_hitCount;
   logic              r_overflow;

   logic              w_startAccept;
   logic              w_issue;
   logic              w_evalActive;
   logic              w_cover;
   logic              w_slotFree;
   logic              w_hit;
   logic              w_overflowHit;
   logic [ADDR_W-1:0] w_idx;
   logic              w_idxLast;
   logic [Y_W:0]      w_spriteTop;
   logic [Y_W:0]      w_spriteEnd;
   logic [Y_W:0]      w_line;

   // A start is only honoured from IDLE; anything else is silently dropped.
   assign w_startAccept = (r_state == IDLE) && i_start;

   // Coverage is computed one bit wider than Y so a sprite near the bottom
   // of the Y range never wraps round to cover the top lines.
   assign w_spriteTop = {1'b0, i_attr_y};
   assign w_spriteEnd = w_spriteTop + HEIGHT;
   assign w_line      = {1'b0, r_lineY};
   assign w_cover     = i_attr_en && (w_spriteTop <= w_line) && (w_line < w_spriteEnd);

   // The RAM response belongs to the read issued in the previous cycle.
   assign w_evalActive  = r_evalValid && ((r_state == SCAN) || (r_state == DRAIN));
   assign w_slotFree    = (r_hitCount < MAX_CNT);
   assign w_hit         = w_evalActive && w_cover && w_slotFree;
   assign w_overflowHit = w_evalActive && w_cover && !w_slotFree;

   // Reads stop in the very cycle overflow is seen so no further sprite is
   // fetched once the line is full.
   assign w_issue = (r_state == SCAN) && !w_overflowHit;

   sprite_idx_ctr u_idxCtr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_startAccept),
      .i_inc   (w_issue),
      .o_idx   (w_idx),
      .o_last  (w_idxLast)
   );

   // Next-state decode: overflow ends the scan ahead of the last index.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (i_start) w_nextState = SCAN;
         SCAN: begin
            if (w_overflowHit) begin
               w_nextState = FIN;
            end else if (w_idxLast) begin
               w_nextState = DRAIN;
            end
         end
         DRAIN:   w_nextState = FIN;
         FIN:     w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // State register and per-line bookkeeping (line latch, eval pipe, results).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_lineY     <= '0;
         r_evalValid <= 1'b0;
         r_evalIdx   <= '0;
         r_hitCount  <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_evalValid <= w_issue;
         if (w_issue) begin
            r_evalIdx <= w_idx;
         end
         if (w_startAccept) begin
            r_lineY    <= i_line_y;
            r_hitCount <= '0;
            r_overflow <= 1'b0;
         end else begin
            if (w_hit) begin
               r_hitCount <= r_hitCount + 1'b1;
            end
            if (w_overflowHit) begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   assign o_attr_rd_en = w_issue;
   assign o_attr_addr  = w_issue ? w_idx : '0;
   assign o_hit_valid  = w_hit;
   assign o_hit_idx    = r_evalIdx;
   assign o_hit_slot   = r_hitCount[SLOT_W-1:0];
   assign o_hit_count  = r_hitCount;
   assign o_overflow   = r_overflow;
   assign o_busy       = (r_state != IDLE);
   assign o_done       = (r_state == FIN);

endmodule

// File: tb/tb_sprite_eval_ctrl.sv
// Directed testbench for sprite_eval_ctrl with a behavioural attribute RAM.
module tb_sprite_eval_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_start = 1'b0;
   logic [7:0] i_line_y = 8'd0;
   logic [7:0] i_attr_y = 8'd0;
   logic       i_attr_en = 1'b0;
   logic       o_attr_rd_en;
   logic [7:0] o_attr_addr;
   logic       o_hit_valid;
   logic [7:0] o_hit_idx;
   logic [2:0] o_hit_slot;
   logic [3:0] o_hit_count;
   logic       o_overflow;
   logic       o_busy;
   logic       o_done;

   logic [7:0] memY [256];
   logic       memEn [256];

   int cyc = 0;
   int base = 0;
   bit active = 1'b0;
   int rel;
   int readCount, addrErr, lastReadRel, maxAddr;
   int hitN, doneCount, doneRel, bothCount;
   int hitIdx [16];
   int hitSlot [16];
   int hitRel [16];
   int checkCount = 0;
   int passCount = 0;

   sprite_eval_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .i_line_y     (i_line_y),
      .o_attr_rd_en (o_attr_rd_en),
      .o_attr_addr  (o_attr_addr),
      .i_attr_y     (i_attr_y),
      .i_attr_en    (i_attr_en),
      .o_hit_valid  (o_hit_valid),
      .o_hit_idx    (o_hit_idx),
      .o_hit_slot   (o_hit_slot),
      .o_hit_count  (o_hit_count),
      .o_overflow   (o_overflow),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Cycle counter advanced on each active edge.
   always @(posedge clk) cyc++;

   // Synchronous attribute RAM: data appears the cycle after a read strobe.
   always @(posedge clk) begin
      if (o_attr_rd_en) begin
         i_attr_y  <= memY[o_attr_addr];
         i_attr_en <= memEn[o_attr_addr];
      end
   end

   // Monitor on the falling edge, logging reads, hits and done relative to start.
   always @(negedge clk) begin
      if (active) begin
         rel = cyc - base;
         if (o_attr_rd_en) begin
            readCount++;
            if (int'(o_attr_addr) != rel - 1) addrErr++;
            lastReadRel = rel;
            if (int'(o_attr_addr) > maxAddr) maxAddr = int'(o_attr_addr);
         end
         if (o_hit_valid) begin
            if (hitN < 16) begin
               hitIdx[hitN]  = int'(o_hit_idx);
               hitSlot[hitN] = int'(o_hit_slot);
               hitRel[hitN]  = rel;
            end
            hitN++;
         end
         if (o_done) begin
            doneCount++;
            doneRel = rel;
         end
         if (o_hit_valid && o_done) bothCount++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic clearMem();
      for (int i = 0; i < 256; i++) begin
         memY[i]  = 8'd0;
         memEn[i] = 1'b0;
      end
   endtask

   task automatic setSprite(input int idx, input logic [7:0] y);
      memY[idx]  = y;
      memEn[idx] = 1'b1;
   endtask

   task automatic clearLog();
      active = 1'b0;
      readCount = 0; addrErr = 0; lastReadRel = -1; maxAddr = -1;
      hitN = 0; doneCount = 0; doneRel = -1; bothCount = 0;
   endtask

   task automatic applyStimulus(input logic [7:0] lineY);
      @(negedge clk);
      clearLog();
      i_line_y = lineY;
      i_start  = 1'b1;
      base     = cyc;
      active   = 1'b1;
      @(negedge clk);
      i_start  = 1'b0;
      i_line_y = 8'hAA;
   endtask

   task automatic pulseStart();
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic waitRel(input int n);
      while (cyc - base < n) @(negedge clk);
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (!o_done && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!o_done) checkOutput("doneTimeout", 32'd0, 32'd1);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int expIdx [3] = '{3, 40, 255};

   initial begin
      clearMem();
      clearLog();
      settle(3);
      checkOutput("rstBusy",   o_busy, 0);
      checkOutput("rstDone",   o_done, 0);
      checkOutput("rstRdEn",   o_attr_rd_en, 0);
      checkOutput("rstAddr",   o_attr_addr, 0);
      checkOutput("rstHitV",   o_hit_valid, 0);
      checkOutput("rstHitIdx", o_hit_idx, 0);
      checkOutput("rstSlot",   o_hit_slot, 0);
      checkOutput("rstCount",  o_hit_count, 0);
      checkOutput("rstOvf",    o_overflow, 0);
      rst_n = 1'b1;
      settle(2);

      $display("[TB] no sprites enabled");
      applyStimulus(8'd100);
      waitDone();
      settle(3);
      checkOutput("t1Reads",    readCount, 256);
      checkOutput("t1AddrErr",  addrErr, 0);
      checkOutput("t1LastRead", lastReadRel, 256);
      checkOutput("t1Hits",     hitN, 0);
      checkOutput("t1DoneRel",  doneRel, 258);
      checkOutput("t1DoneCnt",  doneCount, 1);
      checkOutput("t1Count",    o_hit_count, 0);
      checkOutput("t1Ovf",      o_overflow, 0);
      checkOutput("t1Busy",     o_busy, 0);

      $display("[TB] sprites 3, 40, 255");
      setSprite(3, 8'd95); setSprite(40, 8'd95); setSprite(255, 8'd95);
      applyStimulus(8'd100);
      waitDone();
      settle(3);
      checkOutput("t2Hits", hitN, 3);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("t2Idx%0d", i),  hitIdx[i], expIdx[i]);
         checkOutput($sformatf("t2Slot%0d", i), hitSlot[i], i);
      end
      checkOutput("t2FirstHitRel", hitRel[0], 5);
      checkOutput("t2LastHitRel",  hitRel[2], 257);
      checkOutput("t2Count",       o_hit_count, 3);
      checkOutput("t2DoneRel",     doneRel, 258);
      checkOutput("t2Both",        bothCount, 0);

      $display("[TB] vertical boundaries");
      clearMem();
      setSprite(10, 8'd85); setSprite(11, 8'd84);
      applyStimulus(8'd100);
      waitDone();
      settle(2);
      checkOutput("t3Hits",  hitN, 1);
      checkOutput("t3Idx",   hitIdx[0], 10);
      checkOutput("t3Count", o_hit_count, 1);
      clearMem();
      setSprite(20, 8'd250);
      applyStimulus(8'd5);
      waitDone();
      settle(2);
      checkOutput("t3NoWrapHits", hitN, 0);
      applyStimulus(8'd255);
      waitDone();
      settle(2);
      checkOutput("t3BottomHits", hitN, 1);
      checkOutput("t3BottomIdx",  hitIdx[0], 20);

      $display("[TB] overflow with ten covering sprites");
      clearMem();
      for (int i = 0; i < 10; i++) setSprite(i, 8'd95);
      applyStimulus(8'd100);
      waitDone();
      settle(3);
      checkOutput("t4Hits", hitN, 8);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("t4Idx%0d", i),  hitIdx[i], i);
         checkOutput($sformatf("t4Slot%0d", i), hitSlot[i], i);
      end
      checkOutput("t4MaxAddrOk", (maxAddr <= 9), 1);
      checkOutput("t4AddrErr",   addrErr, 0);
      checkOutput("t4DoneRel",   doneRel, 11);
      checkOutput("t4DoneCnt",   doneCount, 1);
      checkOutput("t4Ovf",       o_overflow, 1);
      checkOutput("t4Count",     o_hit_count, 8);
      checkOutput("t4Both",      bothCount, 0);

      $display("[TB] start while busy is ignored");
      applyStimulus(8'd100);
      waitRel(5);
      pulseStart();
      waitDone();
      pulseStart();
      settle(5);
      checkOutput("t5DoneCnt", doneCount, 1);
      checkOutput("t5DoneRel", doneRel, 11);
      checkOutput("t5Ovf",     o_overflow, 1);
      checkOutput("t5Count",   o_hit_count, 8);
      checkOutput("t5Busy",    o_busy, 0);
      clearMem();
      applyStimulus(8'd100);
      checkOutput("t5FreshCount", o_hit_count, 0);
      checkOutput("t5FreshOvf",   o_overflow, 0);
      checkOutput("t5FreshBusy",  o_busy, 1);
      waitDone();
      settle(2);

      $display("[TB] reset mid-scan");
      setSprite(3, 8'd95); setSprite(40, 8'd95);
      applyStimulus(8'd100);
      waitRel(50);
      checkOutput("t6PreCount", o_hit_count, 2);
      rst_n = 1'b0;
      #1;
      checkOutput("t6Busy",  o_busy, 0);
      checkOutput("t6RdEn",  o_attr_rd_en, 0);
      checkOutput("t6Addr",  o_attr_addr, 0);
      checkOutput("t6Count", o_hit_count, 0);
      checkOutput("t6Done",  o_done, 0);
      settle(5);
      rst_n = 1'b1;
      settle(3);
      checkOutput("t6NoDone", doneCount, 0);
      applyStimulus(8'd100);
      waitDone();
      settle(2);
      checkOutput("t6Reads",   readCount, 256);
      checkOutput("t6AddrErr", addrErr, 0);
      checkOutput("t6Hits",    hitN, 2);
      checkOutput("t6DoneRel", doneRel, 258);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
